// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point operand alignment block.
package fp_pkg;

  // Width of the guard/round/sticky extension appended below each mantissa.
  localparam int GRS_W = 3;

  // Alignment controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_sticky_shr.sv
// Variable logical right shift; every bit shifted out is ORed into bit 0.
// A shift amount of W or more leaves only the sticky bit.
module fp_sticky_shr #(
  parameter int W    = 56,
  parameter int SH_W = 6
) (
  input  logic [W-1:0]    x,
  input  logic [SH_W-1:0] sh,
  output logic [W-1:0]    y
);

  logic [W-1:0] lost_mask;
  logic         sticky;

  // Shift, then fold the bits that fell off the bottom into the LSB.
  always_comb begin
    lost_mask = ~({W{1'b1}} << sh);
    sticky    = |(x & lost_mask);
    y         = x >> sh;
    y[0]      = y[0] | sticky;
  end

endmodule

// File: rtl/fp_align.sv
// Aligns two floating-point operands to the larger exponent, shifting the
// smaller one right by at most STEP bits per cycle with sticky collection.
//
// Handshakes: a transfer happens on a rising edge where en is high and both
// valid and ready are high. in_ready depends only on en and state; out_valid
// depends only on state; results stay stable while out_valid waits for
// out_ready.
module fp_align
  import fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 53,
  parameter int STEP  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W-1:0]       a_man,
  input  logic [MAN_W-1:0]       b_man,
  input  logic [EXP_W-1:0]       a_exp,
  input  logic [EXP_W-1:0]       b_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAN_W+GRS_W-1:0] a_al,
  output logic [MAN_W+GRS_W-1:0] b_al,
  output logic [EXP_W-1:0]       exp_al,
  output logic                   shifted_b,
  output state_t                 dbg_state
);

  localparam int W    = MAN_W + GRS_W;
  localparam int SH_W = $clog2(W + 1);

  state_t             state, state_n;
  logic [W-1:0]       a_r, b_r;
  logic [EXP_W-1:0]   ae_r, be_r;
  logic               sb_r;

  logic               b_small;
  logic [EXP_W-1:0]   d;
  logic [31:0]        d32;
  logic               early;
  logic [SH_W-1:0]    sh_amt;
  logic [EXP_W-1:0]   new_exp;
  logic [W-1:0]       shr_in, shr_out;

  // Distance between exponents and the shift to apply on this ALIGN edge.
  always_comb begin
    b_small = (be_r < ae_r);
    d       = b_small ? (ae_r - be_r) : (be_r - ae_r);
    d32     = 32'(d);
    early   = (d32 > 32'(W - 1));
    if (early)
      sh_amt = SH_W'(W);
    else if (d32 > 32'(STEP))
      sh_amt = SH_W'(STEP);
    else
      sh_amt = SH_W'(d32);
    shr_in  = b_small ? b_r : a_r;
    if (early)
      new_exp = b_small ? ae_r : be_r;
    else
      new_exp = (b_small ? be_r : ae_r) + EXP_W'(sh_amt);
  end

  fp_sticky_shr #(
    .W    (W),
    .SH_W (SH_W)
  ) u_shr (
    .x  (shr_in),
    .sh (sh_amt),
    .y  (shr_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state logic; en low holds the current state.
  always_comb begin
    state_n = state;
    if (en) begin
      case (state)
        IDLE:    if (in_valid) state_n = ALIGN;
        ALIGN:   if (d == '0) state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath registers: capture on acceptance, shift the smaller operand in ALIGN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      ae_r <= '0;
      be_r <= '0;
      sb_r <= 1'b0;
    end else if (en) begin
      if (state == IDLE && in_valid) begin
        a_r  <= {a_man, {GRS_W{1'b0}}};
        b_r  <= {b_man, {GRS_W{1'b0}}};
        ae_r <= a_exp;
        be_r <= b_exp;
        sb_r <= 1'b0;
      end else if (state == ALIGN && d != '0) begin
        if (b_small) begin
          b_r  <= shr_out;
          be_r <= new_exp;
          sb_r <= 1'b1;
        end else begin
          a_r  <= shr_out;
          ae_r <= new_exp;
        end
      end
    end
  end

  // Output views of the registered datapath.
  always_comb begin
    exp_al = (ae_r >= be_r) ? ae_r : be_r;
  end

  assign a_al      = a_r;
  assign b_al      = b_r;
  assign shifted_b = sb_r;
  assign in_ready  = en && (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fp_align.sv
// Bench for fp_align: unit 0 uses STEP=1, unit 1 uses STEP=8.
module tb_fp_align;
  import fp_pkg::*;

  localparam int EXP_W = 11;
  localparam int MAN_W = 53;
  localparam int W     = MAN_W + 3;

  typedef struct {
    int               u;
    logic [MAN_W-1:0] am;
    logic [EXP_W-1:0] ae;
    logic [MAN_W-1:0] bm;
    logic [EXP_W-1:0] be;
    logic [W-1:0]     ra;
    logic [W-1:0]     rb;
    logic [EXP_W-1:0] re;
    logic             rsb;
    int               lat;
    string            name;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            rst, en, in_valid, out_ready;
  logic [1:0]            in_ready, out_valid, shifted_b;
  logic [MAN_W-1:0]      a_man, b_man;
  logic [EXP_W-1:0]      a_exp, b_exp;
  logic [1:0][W-1:0]     a_al, b_al;
  logic [1:0][EXP_W-1:0] exp_al;
  state_t                st0, st1;

  int n_cmp = 0;
  int n_err = 0;

  fp_align #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STEP(1)) dut (
    .clk(clk), .rst(rst[0]), .en(en[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_man(a_man), .b_man(b_man), .a_exp(a_exp), .b_exp(b_exp),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .a_al(a_al[0]), .b_al(b_al[0]),
    .exp_al(exp_al[0]), .shifted_b(shifted_b[0]), .dbg_state(st0)
  );

  fp_align #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STEP(8)) dut8 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_man(a_man), .b_man(b_man), .a_exp(a_exp), .b_exp(b_exp),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .a_al(a_al[1]), .b_al(b_al[1]),
    .exp_al(exp_al[1]), .shifted_b(shifted_b[1]), .dbg_state(st1)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one-shot alignment by the full exponent difference.
  function automatic longint unsigned align_ref(input longint unsigned m, input int d);
    longint unsigned mask;
    if (d > W - 1) return (m != 0) ? 64'd1 : 64'd0;
    mask = (64'd1 << d) - 64'd1;
    return (m >> d) | (((m & mask) != 0) ? 64'd1 : 64'd0);
  endfunction

  function automatic vec_t model(input int u, input logic [MAN_W-1:0] am, input logic [EXP_W-1:0] ae,
                                 input logic [MAN_W-1:0] bm, input logic [EXP_W-1:0] be);
    vec_t v;
    longint unsigned ma, mb, r;
    int d, step, n;
    step = (u == 0) ? 1 : 8;
    ma = 64'(am) << 3;
    mb = 64'(bm) << 3;
    d = (ae >= be) ? int'(ae) - int'(be) : int'(be) - int'(ae);
    v.u = u; v.am = am; v.ae = ae; v.bm = bm; v.be = be; v.name = "rand";
    v.re = (ae >= be) ? ae : be;
    v.ra = ma[W-1:0];
    v.rb = mb[W-1:0];
    v.rsb = 1'b0;
    if (ae > be) begin
      r = align_ref(mb, d);
      v.rb = r[W-1:0];
      v.rsb = 1'b1;
    end else if (be > ae) begin
      r = align_ref(ma, d);
      v.ra = r[W-1:0];
    end
    if (d == 0) n = 0;
    else if (d > W - 1) n = 1;
    else n = (d + step - 1) / step;
    v.lat = n + 1;
    return v;
  endfunction

  function automatic vec_t mk(input int u, input logic [MAN_W-1:0] am, input logic [EXP_W-1:0] ae,
                              input logic [MAN_W-1:0] bm, input logic [EXP_W-1:0] be,
                              input logic [W-1:0] ra, input logic [W-1:0] rb,
                              input logic [EXP_W-1:0] re, input logic rsb, input int lat, input string name);
    vec_t v;
    v.u = u; v.am = am; v.ae = ae; v.bm = bm; v.be = be;
    v.ra = ra; v.rb = rb; v.re = re; v.rsb = rsb; v.lat = lat; v.name = name;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Runs one operation; latency is counted in edges after the acceptance edge.
  task automatic run_op(input vec_t v, input int stall_len, input int bp_len);
    int u, w, lat;
    u = v.u;
    w = 0;
    while (!in_ready[u] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({v.name, " in_ready before"}, 64'(in_ready[u]), 64'd1);
    a_man = v.am; a_exp = v.ae; b_man = v.bm; b_exp = v.be;
    in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    a_man = $urandom(); b_man = $urandom(); a_exp = '0; b_exp = '0;
    chk({v.name, " in_ready busy"}, 64'(in_ready[u]), 64'd0);
    lat = 0;
    while (!out_valid[u] && lat < 300) begin
      if (lat == 1 && stall_len > 0) en[u] = 1'b0;
      if (lat == 1 + stall_len) en[u] = 1'b1;
      @(posedge clk); #1; lat++;
    end
    en[u] = 1'b1;
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat + stall_len));
    chk({v.name, " a_al"}, 64'(a_al[u]), 64'(v.ra));
    chk({v.name, " b_al"}, 64'(b_al[u]), 64'(v.rb));
    chk({v.name, " exp_al"}, 64'(exp_al[u]), 64'(v.re));
    chk({v.name, " shifted_b"}, 64'(shifted_b[u]), 64'(v.rsb));
    if (!out_valid[u]) begin
      rst[u] = 1'b1; @(posedge clk); #1; rst[u] = 1'b0;
    end else begin
      for (int i = 0; i < bp_len; i++) begin
        @(posedge clk); #1;
        chk({v.name, " bp out_valid"}, 64'(out_valid[u]), 64'd1);
        chk({v.name, " bp in_ready"}, 64'(in_ready[u]), 64'd0);
        chk({v.name, " bp a_al"}, 64'(a_al[u]), 64'(v.ra));
        chk({v.name, " bp b_al"}, 64'(b_al[u]), 64'(v.rb));
        chk({v.name, " bp exp_al"}, 64'(exp_al[u]), 64'(v.re));
        chk({v.name, " bp shifted_b"}, 64'(shifted_b[u]), 64'(v.rsb));
      end
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
      chk({v.name, " out_valid drop"}, 64'(out_valid[u]), 64'd0);
      chk({v.name, " in_ready back"}, 64'(in_ready[u]), 64'd1);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[8];
  vec_t rv;

  initial begin
    logic [MAN_W-1:0] ram, rbm;
    int rae, rbe, off, ru;

    rst = 2'b11; en = 2'b11; in_valid = 2'b00; out_ready = 2'b00;
    a_man = '0; b_man = '0; a_exp = '0; b_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    for (int u = 0; u < 2; u++) begin
      chk("reset a_al", 64'(a_al[u]), 64'd0);
      chk("reset b_al", 64'(b_al[u]), 64'd0);
      chk("reset exp_al", 64'(exp_al[u]), 64'd0);
      chk("reset shifted_b", 64'(shifted_b[u]), 64'd0);
      chk("reset out_valid", 64'(out_valid[u]), 64'd0);
      chk("reset in_ready", 64'(in_ready[u]), 64'd1);
    end
    chk("reset state0", 64'(st0), 64'(IDLE));
    chk("reset state1", 64'(st1), 64'(IDLE));

    // Directed vectors with hand-derived expectations.
    tbl[0] = mk(0, 53'h10000000000000, 11'h400, 53'h10000000000000, 11'h400,
                56'h80000000000000, 56'h80000000000000, 11'h400, 1'b0, 1, "equal");
    tbl[1] = mk(0, 53'h10000000000000, 11'h400, 53'h10000000000000, 11'h3FE,
                56'h80000000000000, 56'h20000000000000, 11'h400, 1'b1, 3, "shift2");
    tbl[2] = mk(0, 53'h10000000000000, 11'h404, 53'h10000000000001, 11'h400,
                56'h80000000000000, 56'h08000000000001, 11'h404, 1'b1, 5, "sticky");
    tbl[3] = mk(0, 53'h1FFFFFFFFFFFFF, 11'h300, 53'h10000000000000, 11'h400,
                56'h00000000000001, 56'h80000000000000, 11'h400, 1'b0, 2, "early");
    tbl[4] = mk(0, 53'h10000000000001, 11'h000, 53'h1ABCDEF0123456, 11'h001,
                56'h40000000000004, 56'hD5E6F78091A2B0, 11'h001, 1'b0, 2, "zero_exp");
    tbl[5] = mk(1, 53'h10000000000000, 11'h414, 53'h10000000000000, 11'h400,
                56'h80000000000000, 56'h00000800000000, 11'h414, 1'b1, 4, "step8_d20");
    tbl[6] = mk(1, 53'h10000000000000, 11'h437, 53'h10000000000000, 11'h400,
                56'h80000000000000, 56'h00000000000001, 11'h437, 1'b1, 8, "step8_d55");
    tbl[7] = mk(1, 53'h10000000000000, 11'h438, 53'h10000000000000, 11'h400,
                56'h80000000000000, 56'h00000000000001, 11'h438, 1'b1, 2, "step8_d56");
    for (int i = 0; i < 8; i++) run_op(tbl[i], 0, 0);

    // Backpressure: result held for 5 cycles with out_ready low.
    rv = tbl[1]; rv.name = "backpressure";
    run_op(rv, 0, 5);

    // Stall: en low for 3 cycles in ALIGN stretches latency by 3.
    rv = tbl[2]; rv.name = "stall";
    run_op(rv, 3, 0);

    // Reset abort: d=40 on STEP=8, rst on the third ALIGN edge.
    a_man = 53'h10000000000000; b_man = 53'h10000000000000;
    a_exp = 11'h428; b_exp = 11'h400;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort pre shifted_b", 64'(shifted_b[1]), 64'd1);
    chk("abort pre out_valid", 64'(out_valid[1]), 64'd0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("abort state", 64'(st1), 64'(IDLE));
    chk("abort out_valid", 64'(out_valid[1]), 64'd0);
    chk("abort a_al", 64'(a_al[1]), 64'd0);
    chk("abort b_al", 64'(b_al[1]), 64'd0);
    chk("abort exp_al", 64'(exp_al[1]), 64'd0);
    chk("abort shifted_b", 64'(shifted_b[1]), 64'd0);
    chk("abort in_ready", 64'(in_ready[1]), 64'd1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 160; i++) begin
      ru = i % 2;
      ram = {$urandom(), $urandom()};
      rbm = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) ram[MAN_W-1] = 1'b1;
      if ($urandom_range(0, 3) != 0) rbm[MAN_W-1] = 1'b1;
      rae = $urandom_range(0, 2047);
      if ($urandom_range(0, 7) == 0) begin
        rbe = $urandom_range(0, 2047);
      end else begin
        off = $urandom_range(0, 140) - 70;
        rbe = rae + off;
        if (rbe < 0) rbe = 0;
        if (rbe > 2047) rbe = 2047;
      end
      rv = model(ru, ram, EXP_W'(rae), rbm, EXP_W'(rbe));
      run_op(rv, 0, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 SHALL have parameter EXP_W, default 11, exponent width (biased, unsigned).
REQ-002 SHALL have parameter MAN_W, default 53, mantissa width including hidden bit.
REQ-003 SHALL have parameter STEP, default 1, max right-shift bits per cycle; legal values are powers of two, 1..32.
REQ-004 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, global stall; 0 freezes all registers.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the operand handshake.
REQ-008 SHALL have ports a_man and b_man, input, MAN_W, operand mantissas.
REQ-009 SHALL have ports a_exp and b_exp, input, EXP_W, operand exponents.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-011 SHALL have ports a_al and b_al, output, MAN_W+3, aligned mantissas with guard, round and sticky as the 3 LSBs.
REQ-012 SHALL have port exp_al, output, EXP_W, the common exponent (max of inputs).
REQ-013 SHALL have port shifted_b, output, 1; 1 means B was the shifted operand, 0 means A or none.

Function
REQ-014 SHALL implement FSM IDLE -> ALIGN -> DONE -> IDLE; no transition or register update while en=0.
REQ-015 SHALL drive in_ready = en AND (state==IDLE), and out_valid = (state==DONE).
REQ-016 SHALL, on an IDLE edge with en AND in_valid, latch each mantissa extended by 3 zero LSBs, latch both exponents, and enter ALIGN.
REQ-017 SHALL, on each ALIGN edge, compare exponents as unsigned values and set d = |a_exp - b_exp|.
REQ-018 SHALL, in ALIGN with d=0, enter DONE with mantissas unchanged.
REQ-019 SHALL, in ALIGN with 0<d<=MAN_W+2, right-shift the smaller-exponent mantissa by s=min(d,STEP), OR all shifted-out bits into bit0 (sticky), and add s to its exponent.
REQ-020 SHALL, in ALIGN with d>MAN_W+2, early-out: zero the smaller mantissa except bit0 = OR of all its bits, set its exponent to the larger, and do so in one edge.
REQ-021 SHALL set shifted_b on the first shifting edge and hold it until the next acceptance, which clears it.
REQ-022 SHALL, given n = ceil(d/STEP) shift edges (n=1 for early-out), raise out_valid after acceptance edge k+n+1.
REQ-023 SHALL hold a_al, b_al, exp_al and shifted_b stable in DONE until an edge with en AND out_ready, then return to IDLE.
REQ-024 SHALL keep in_ready low until the return to IDLE, with no overlap of operations.
REQ-025 SHALL treat a zero exponent as an ordinary value, with no denormal or special-value handling.

Reset
REQ-026 SHALL, on a rst edge, set state to IDLE and clear all datapath registers, so that a_al=0, b_al=0, exp_al=0, shifted_b=0 and out_valid=0.
REQ-027 SHALL give rst priority over en and over both handshakes.
REQ-028 SHALL make rst mid-ALIGN or mid-DONE abort the operation and discard the result.

Structure
REQ-029 SHALL place in shared package fp_pkg: the FSM state enum and the constant GRS_W=3.
REQ-030 SHALL use one combinational sub-module, fp_sticky_shr (variable right shift with sticky OR), instantiated once for the selected operand.

Verification (defaults unless noted)
REQ-031 SHALL check: a_exp=b_exp=0x400, a_man=b_man=0x10000000000000 -> out_valid after edge k+1; a_al=b_al=56'h80000000000000; exp_al=0x400; shifted_b=0.
REQ-032 SHALL check: a_exp=0x400, b_exp=0x3FE, b_man=0x10000000000000 -> 2 shift edges; b_al=56'h20000000000000; exp_al=0x400; shifted_b=1; out_valid after edge k+3.
REQ-033 SHALL check sticky: a_exp=0x404, b_exp=0x400, b_man=0x10000000000001 -> b_al=56'h08000000000001.
REQ-034 SHALL check early-out: a_exp=0x300, b_exp=0x400, a_man=0x1FFFFFFFFFFFFF -> a_al=56'h1; exp_al=0x400; shifted_b=0; out_valid after edge k+2.
REQ-035 SHALL check backpressure and stall: out_ready=0 for 5 cycles -> outputs stable, in_ready=0; en=0 for 3 cycles mid-ALIGN -> latency extends by exactly 3.
REQ-036 SHALL check STEP=8 and reset: d=20 -> 3 shift edges (8, 8, 4); separately, d=40 with rst asserted on the 3rd ALIGN edge -> next cycle IDLE, out_valid=0, a_al=b_al=0.
